mem_port_arbiter: RTL and testbench

- Shares one external memory pad bus between the core's instruction-fetch port and data-memory port, so the pad ring needs a single address/data/strobe set instead of two.
- Sits between the CPU core and the I/O pad instances in the chip top.
- Serialises IF and DM transactions with round-robin arbitration and a req/ack handshake on each side.
- Provides a watchdog that aborts hung external accesses.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 8;

  // Read data returned to a requester whose access the watchdog aborted.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is the IF side, bit 1 the DM side.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  grant_t last_grant;

  // Reset to DM so the IF side wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= GNT_DM;
    end else if (update && (gnt != 2'b00)) begin
      last_grant <= gnt[0] ? GNT_IF : GNT_DM;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_DM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data-memory accesses onto one external
// pad bus with round-robin arbitration and a watchdog on hung accesses.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,  // must be < 2**CNT_W
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output state_t            dbg_state
);

  // Handshake: each requester raises req (level) and holds it with stable
  // addr/we/wdata until its ack pulses for one cycle; rdata is valid in that
  // cycle. Externally mem_req is held with stable mem_* until mem_ack.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_d;
  grant_t            cur, cur_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d, mem_wdata_d, done_data;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_we_d;
  logic              if_ack_d, dm_ack_d, mem_req_d, err_d;
  logic [1:0]        gnt;
  logic              arb_update;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({dm_req, if_req}),
    .update (arb_update),
    .gnt    (gnt)
  );

  assign dbg_state = state;
  assign done_data = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_DATA);

  always_comb begin
    state_d     = state;
    cur_d       = cur;
    cnt_d       = cnt;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    err_d       = err;
    arb_update  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          arb_update = 1'b1;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
          if (gnt[0]) begin
            cur_d       = GNT_IF;
            mem_addr_d  = if_addr;
            mem_we_d    = 4'b0000;
            mem_wdata_d = '0;
          end else begin
            cur_d       = GNT_DM;
            mem_addr_d  = dm_addr;
            mem_we_d    = dm_we;
            mem_wdata_d = dm_wdata;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt + CNT_W'(1);
        // A real mem_ack in the final watchdog cycle still completes normally.
        if (mem_ack || (cnt == CNT_LAST)) begin
          mem_req_d = 1'b0;
          mem_we_d  = 4'b0000;
          state_d   = RESP;
          if (!mem_ack) err_d = 1'b1;
          if (cur == GNT_IF) begin
            if_rdata_d = done_data;
            if_ack_d   = 1'b1;
          end else begin
            dm_rdata_d = done_data;
            dm_ack_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= GNT_IF;
      cnt       <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cur       <= cur_d;
      cnt       <= cnt_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_ack    <= if_ack_d;
      dm_ack    <= dm_ack_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses are queued as
// stimulus is issued and a monitor compares them against every ack.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int EW      = DATA_W + 2;  // {dm_side, err, rdata}

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err;
  state_t            dbg_state;

  int total;
  int bad;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] sb_got;
  logic [EW-1:0] sb_want;

  // Memory model knobs: wait states before mem_ack, or never ack at all.
  int wait_states;
  bit mem_never;
  int wcnt;

  bit gap_en;
  bit gap_armed;
  int low_run;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "global timeout");
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_model(input logic [15:0] a, input logic [3:0] we);
    if (we != 4'b0000) return 32'h0000_0000;
    if (a == 16'h0040) return 32'h0000_0013;
    return {a ^ 16'hA5A5, a};
  endfunction

  assign mem_rdata = mem_model(mem_addr, mem_we);
  assign mem_ack   = mem_req && !mem_never && (wcnt == wait_states);

  always @(posedge clk) wcnt <= mem_req ? wcnt + 1 : 0;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit dm, input bit e, input logic [31:0] d);
    exp_q.push_back({dm, e, d});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (if_ack && dm_ack) begin
      total++;
      bad++;
      $display("FAIL dual_ack: got if_ack=1 dm_ack=1 expected at most one");
    end else if (if_ack || dm_ack) begin
      sb_got = {dm_ack, err, (dm_ack ? dm_rdata : if_rdata)};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %h expected no response", sb_got);
      end else begin
        sb_want = exp_q.pop_front();
        check("sb_resp", 64'(sb_got), 64'(sb_want));
      end
    end
    if (!mem_req && (mem_we != 4'b0000)) begin
      total++;
      bad++;
      $display("FAIL we_idle: got mem_we=%h with mem_req=0 expected 0", mem_we);
    end
    if (mem_req) begin
      if (gap_en && gap_armed) check("mem_req_gap", 64'(low_run), 64'd2);
      gap_armed = gap_en;
      low_run   = 0;
    end else begin
      low_run++;
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_ack(input bit dm, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = dm ? dm_ack : if_ack;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: got no ack within 64 cycles expected ack", name);
    end
  endtask

  task automatic if_access(input logic [15:0] addr);
    if_addr = addr;
    if_req  = 1'b1;
    wait_ack(1'b0, "if_ack_wait");
    if_req  = 1'b0;
  endtask

  task automatic dm_access(input logic [3:0] we, input logic [15:0] addr, input logic [31:0] wdata);
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = wdata;
    dm_req   = 1'b1;
    wait_ack(1'b1, "dm_ack_wait");
    dm_req   = 1'b0;
    dm_we    = 4'b0000;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int n_busy;
  int n_ack;

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 4'b0000; dm_addr = '0; dm_wdata = '0;
    wait_states = 0; mem_never = 1'b0;
    gap_en = 1'b0; gap_armed = 1'b0; low_run = 0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {if_rdata, dm_rdata, mem_wdata[15:0]},
          64'd0);
    check("reset_ctrl",
          64'({if_ack, dm_ack, mem_req, mem_we, mem_addr, mem_wdata[31:16], err}),
          64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Single zero-wait IF read.
    expect_resp(1'b0, 1'b0, 32'h0000_0013);
    fork
      if_access(16'h0040);
      begin
        @(negedge clk);
        check("t1_mem_req", 64'(mem_req), 64'd1);
        check("t1_mem_addr", 64'(mem_addr), 64'h0040);
        check("t1_mem_we", 64'(mem_we), 64'h0);
        @(negedge clk);
        check("t1_if_ack", 64'(if_ack), 64'd1);
        check("t1_dm_ack", 64'(dm_ack), 64'd0);
      end
    join
    @(negedge clk);

    // Dual contention straight out of reset: IF, DM, IF, DM.
    pulse_reset();
    gap_en = 1'b1; gap_armed = 1'b0;
    expect_resp(1'b0, 1'b0, 32'hA4A5_0100);
    expect_resp(1'b1, 1'b0, 32'hA7A5_0200);
    expect_resp(1'b0, 1'b0, 32'hA4A1_0104);
    expect_resp(1'b1, 1'b0, 32'hA7A1_0204);
    fork
      begin if_access(16'h0100); if_access(16'h0104); end
      begin dm_access(4'b0000, 16'h0200, '0); dm_access(4'b0000, 16'h0204, '0); end
    join
    repeat (2) @(negedge clk);
    gap_en = 1'b0;

    // mem_ack arriving in the last watchdog cycle completes normally.
    wait_states = TIMEOUT - 1;
    expect_resp(1'b1, 1'b0, 32'hA1A5_0400);
    n_busy = 0;
    fork
      dm_access(4'b0000, 16'h0400, '0);
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (mem_req) n_busy++;
      end
    join
    check("t3_busy_cycles", 64'(n_busy), 64'd8);
    check("t3_err", 64'(err), 64'd0);

    // DM write with 5 wait states: bus held stable for 6 cycles.
    wait_states = 5;
    expect_resp(1'b1, 1'b0, 32'h0000_0000);
    n_busy = 0; n_ack = 0;
    fork
      dm_access(4'b1111, 16'h8000, 32'hCAFE_F00D);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (dm_ack) n_ack++;
        if (mem_req) begin
          n_busy++;
          check("t4_stable", 64'({mem_we, mem_addr, mem_wdata}), {12'h0, 4'hF, 16'h8000, 32'hCAFE_F00D});
        end
      end
    join
    check("t4_busy_cycles", 64'(n_busy), 64'd6);
    check("t4_ack_pulses", 64'(n_ack), 64'd1);
    check("t4_err", 64'(err), 64'd0);

    // Memory never answers: watchdog aborts after TIMEOUT busy cycles.
    mem_never = 1'b1;
    wait_states = 0;
    expect_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    n_busy = 0;
    fork
      dm_access(4'b0000, 16'h0300, '0);
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (mem_req) n_busy++;
      end
    join
    check("t5_busy_cycles", 64'(n_busy), 64'd8);
    check("t5_err_set", 64'(err), 64'd1);
    mem_never = 1'b0;
    expect_resp(1'b0, 1'b1, 32'h0000_0013);
    if_access(16'h0040);
    @(negedge clk);
    check("t5_err_sticky", 64'(err), 64'd1);

    // Reset in the middle of a hung access, then a tie goes to IF.
    mem_never = 1'b1;
    dm_addr = 16'h0700; dm_we = 4'b0000; dm_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy_before_rst", 64'({mem_req, dbg_state}), {61'd0, 1'b1, BUSY});
    rst = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check("t6_rst_outputs", 64'({mem_req, if_ack, dm_ack, err, mem_we, mem_addr}), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'(IDLE));
    mem_never = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_resp(1'b0, 1'b0, 32'hA0A5_0500);
    expect_resp(1'b1, 1'b0, 32'hA3A5_0600);
    fork
      if_access(16'h0500);
      dm_access(4'b0000, 16'h0600, '0);
      begin
        @(negedge clk);
        check("t6_first_grant", 64'(mem_addr), 64'h0500);
      end
    join

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
